// File: rtl/datapath_mc.sv
// Multi-channel MVM datapath: per-channel dot product, addressed accumulation, optional
// reduce-add and int8 requantisation, feeding a credit-controlled output FIFO.
module datapath_mc #(
  parameter int LANES      = 64,
  parameter int IPREC      = 8,
  parameter int OPREC      = 32,
  parameter int NUM_CH     = 4,
  parameter int MEM_DEPTH  = 512,
  parameter int ADDRW      = $clog2(MEM_DEPTH),
  parameter int SHIFTW     = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [LANES*IPREC-1:0]        i_dataa,
  input  logic [NUM_CH*LANES*IPREC-1:0] i_datab,
  input  logic [NUM_CH*OPREC-1:0]       i_datac,
  input  logic [ADDRW-1:0]              i_accum_addr,
  input  logic                          i_accum,
  input  logic                          i_last,
  input  logic                          i_reduce,
  input  logic [1:0]                    i_mode,
  input  logic [SHIFTW-1:0]             i_shift,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [NUM_CH*OPREC-1:0]       o_result
);
  localparam int LOGL    = $clog2(LANES);
  localparam int DOT_LAT = 1 + LOGL;
  localparam int NODES   = 2*LANES - 1;
  localparam int FPTRW   = $clog2(FIFO_DEPTH);
  localparam int CNTW    = FPTRW + 2;
  localparam int QW      = 8;

  typedef struct packed {
    logic [ADDRW-1:0]        addr;
    logic                    accum;
    logic                    last;
    logic                    reduce;
    logic [1:0]              mode;
    logic [SHIFTW-1:0]       shift;
    logic [NUM_CH*OPREC-1:0] datac;
  } ctrl_t;

  function automatic logic signed [OPREC-1:0] mul_ext(input logic signed [IPREC-1:0] x,
                                                      input logic signed [IPREC-1:0] y);
    logic signed [2*IPREC-1:0] p;
    p = x * y;
    return {{(OPREC-2*IPREC){p[2*IPREC-1]}}, p};
  endfunction

  // Round-half-up shift at OPREC+1 bits so the rounding add cannot overflow, then clamp to int8.
  function automatic logic [OPREC-1:0] requant(input logic [OPREC-1:0] r,
                                               input logic [1:0] mode,
                                               input logic [SHIFTW-1:0] sh);
    logic signed [OPREC:0] wide;
    logic signed [OPREC:0] rnd;
    logic signed [OPREC:0] q;
    logic [OPREC-1:0]      sat;
    logic                  in_range;
    wide     = {r[OPREC-1], r};
    rnd      = ({{OPREC{1'b0}}, 1'b1} << sh) >> 1;
    q        = (wide + rnd) >>> sh;
    in_range = (q[OPREC:QW-1] == '0) || (&q[OPREC:QW-1]);
    if (in_range)
      sat = {{(OPREC-QW){q[QW-1]}}, q[QW-1:0]};
    else if (q[OPREC])
      sat = {{(OPREC-QW){1'b1}}, 1'b1, {(QW-1){1'b0}}};
    else
      sat = {{(OPREC-QW){1'b0}}, 1'b0, {(QW-1){1'b1}}};
    case (mode)
      2'd1:    return sat;
      2'd2:    return sat[OPREC-1] ? '0 : sat;
      default: return r;
    endcase
  endfunction

  logic accept;
  logic push;
  logic pop;
  ctrl_t ctrl_in;

  logic [DOT_LAT-1:0]      dot_vld;
  ctrl_t                   dot_ctrl [DOT_LAT];
  logic signed [OPREC-1:0] node [NUM_CH][NODES];

  logic                    a1_vld;
  ctrl_t                   a1_ctrl;
  logic [NUM_CH*OPREC-1:0] a1_dot;
  logic [NUM_CH*OPREC-1:0] a1_old;
  logic [NUM_CH*OPREC-1:0] s_comb;
  logic                    fwd;
  logic [OPREC-1:0]        acc_mem [NUM_CH][MEM_DEPTH];

  logic                    s_vld;
  logic [NUM_CH*OPREC-1:0] s_val;
  logic                    s_reduce;
  logic [1:0]              s_mode;
  logic [SHIFTW-1:0]       s_shift;
  logic [NUM_CH*OPREC-1:0] s_datac;

  logic                    r_vld;
  logic [NUM_CH*OPREC-1:0] r_val;
  logic [1:0]              r_mode;
  logic [SHIFTW-1:0]       r_shift;

  logic                    q_vld;
  logic [NUM_CH*OPREC-1:0] q_val;

  logic [NUM_CH*OPREC-1:0] fifo_mem [FIFO_DEPTH];
  logic [FPTRW-1:0]        wr_ptr;
  logic [FPTRW-1:0]        rd_ptr;
  logic [CNTW-1:0]         fifo_count;
  logic [CNTW-1:0]         inflight;

  // Every accepted last beat holds a FIFO slot from accept until write, so the FIFO cannot overflow.
  assign o_ready  = !rst && ((fifo_count + inflight) < CNTW'(FIFO_DEPTH));
  assign accept   = i_valid && o_ready;
  assign push     = q_vld;
  assign o_valid  = (fifo_count != '0);
  assign pop      = o_valid && i_ready;
  assign o_result = o_valid ? fifo_mem[rd_ptr] : '0;
  assign fwd      = a1_vld && (a1_ctrl.addr == dot_ctrl[DOT_LAT-1].addr);

  always_comb begin
    ctrl_in.addr   = i_accum_addr;
    ctrl_in.accum  = i_accum;
    ctrl_in.last   = i_last;
    ctrl_in.reduce = i_reduce;
    ctrl_in.mode   = i_mode;
    ctrl_in.shift  = i_shift;
    ctrl_in.datac  = i_datac;
  end

  always_comb begin
    s_comb = '0;
    for (int c = 0; c < NUM_CH; c++)
      s_comb[c*OPREC +: OPREC] = a1_ctrl.accum ? a1_old[c*OPREC +: OPREC] + a1_dot[c*OPREC +: OPREC]
                                               : a1_dot[c*OPREC +: OPREC];
  end

  // Products register at the accept edge; each later cycle folds one adder-tree level.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < LANES; k++)
        node[c][k] <= mul_ext(i_dataa[k*IPREC +: IPREC], i_datab[(c*LANES+k)*IPREC +: IPREC]);
      for (int l = 1; l <= LOGL; l++)
        for (int i = 0; i < (LANES >> l); i++)
          node[c][2*LANES - 2*(LANES >> l) + i] <=
            node[c][2*LANES - 4*(LANES >> l) + 2*i] + node[c][2*LANES - 4*(LANES >> l) + 2*i + 1];
    end
  end

  // The beat being written this edge is forwarded to a same-address read in the next beat.
  always_ff @(posedge clk) begin
    dot_ctrl[0] <= ctrl_in;
    for (int j = 1; j < DOT_LAT; j++)
      dot_ctrl[j] <= dot_ctrl[j-1];
    a1_ctrl <= dot_ctrl[DOT_LAT-1];
    for (int c = 0; c < NUM_CH; c++) begin
      a1_dot[c*OPREC +: OPREC] <= node[c][NODES-1];
      a1_old[c*OPREC +: OPREC] <= fwd ? s_comb[c*OPREC +: OPREC]
                                      : acc_mem[c][dot_ctrl[DOT_LAT-1].addr];
      if (a1_vld)
        acc_mem[c][a1_ctrl.addr] <= s_comb[c*OPREC +: OPREC];
    end
  end

  always_ff @(posedge clk) begin
    s_val    <= s_comb;
    s_reduce <= a1_ctrl.reduce;
    s_mode   <= a1_ctrl.mode;
    s_shift  <= a1_ctrl.shift;
    s_datac  <= a1_ctrl.datac;
    r_mode   <= s_mode;
    r_shift  <= s_shift;
    for (int c = 0; c < NUM_CH; c++) begin
      r_val[c*OPREC +: OPREC] <= s_reduce ? s_val[c*OPREC +: OPREC] + s_datac[c*OPREC +: OPREC]
                                          : s_val[c*OPREC +: OPREC];
      q_val[c*OPREC +: OPREC] <= requant(r_val[c*OPREC +: OPREC], r_mode, r_shift);
    end
    if (push)
      fifo_mem[wr_ptr] <= q_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_vld    <= '0;
      a1_vld     <= 1'b0;
      s_vld      <= 1'b0;
      r_vld      <= 1'b0;
      q_vld      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      dot_vld <= {dot_vld[DOT_LAT-2:0], accept};
      a1_vld  <= dot_vld[DOT_LAT-1];
      s_vld   <= a1_vld && a1_ctrl.last;
      r_vld   <= s_vld;
      q_vld   <= r_vld;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (!push && pop)
        fifo_count <= fifo_count - 1'b1;
      if ((accept && i_last) && !push)
        inflight <= inflight + 1'b1;
      else if (!(accept && i_last) && push)
        inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: a vector table of single-beat results plus hand-written
// sequences for latency, accumulation forwarding, backpressure and mid-stream reset.
module tb_datapath_mc;
  localparam int LANES  = 64;
  localparam int IPREC  = 8;
  localparam int OPREC  = 32;
  localparam int NUM_CH = 4;
  localparam int ADDRW  = 9;
  localparam int SHIFTW = 5;

  logic                          clk;
  logic                          rst;
  logic                          i_valid;
  logic                          o_ready;
  logic [LANES*IPREC-1:0]        i_dataa;
  logic [NUM_CH*LANES*IPREC-1:0] i_datab;
  logic [NUM_CH*OPREC-1:0]       i_datac;
  logic [ADDRW-1:0]              i_accum_addr;
  logic                          i_accum;
  logic                          i_last;
  logic                          i_reduce;
  logic [1:0]                    i_mode;
  logic [SHIFTW-1:0]             i_shift;
  logic                          o_valid;
  logic                          i_ready;
  logic [NUM_CH*OPREC-1:0]       o_result;

  datapath_mc dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_dataa      (i_dataa),
    .i_datab      (i_datab),
    .i_datac      (i_datac),
    .i_accum_addr (i_accum_addr),
    .i_accum      (i_accum),
    .i_last       (i_last),
    .i_reduce     (i_reduce),
    .i_mode       (i_mode),
    .i_shift      (i_shift),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result)
  );

  // A beat drives value a on lanes [0, nl) and zero elsewhere; channel c uses weight b[c] on every lane.
  typedef struct packed {
    logic [6:0]       nl;
    logic [7:0]       a;
    logic [3:0][7:0]  b;
    logic [3:0][31:0] dc;
    logic [8:0]       addr;
    logic             reduce;
    logic [1:0]       mode;
    logic [4:0]       shift;
    logic [3:0][31:0] exp;
  } vec_t;

  int   checks;
  int   errors;
  vec_t vq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0][31:0] mk4(input int e0, input int e1, input int e2, input int e3);
    logic [3:0][31:0] r;
    r[0] = 32'(e0);
    r[1] = 32'(e1);
    r[2] = 32'(e2);
    r[3] = 32'(e3);
    return r;
  endfunction

  function automatic vec_t makeVec(input int nl, input int a,
                                   input int b0, input int b1, input int b2, input int b3,
                                   input int c0, input int c1, input int c2, input int c3,
                                   input int addr, input int red, input int mode, input int shift,
                                   input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.nl     = 7'(nl);
    v.a      = 8'(a);
    v.b[0]   = 8'(b0);
    v.b[1]   = 8'(b1);
    v.b[2]   = 8'(b2);
    v.b[3]   = 8'(b3);
    v.dc     = mk4(c0, c1, c2, c3);
    v.addr   = 9'(addr);
    v.reduce = red[0];
    v.mode   = 2'(mode);
    v.shift  = 5'(shift);
    v.exp    = mk4(e0, e1, e2, e3);
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
               name, got, $signed(got), exp, $signed(exp));
    end
  endtask

  task automatic setInputs(input vec_t v, input logic acc, input logic last);
    for (int k = 0; k < LANES; k++)
      i_dataa[k*IPREC +: IPREC] = (k < int'(v.nl)) ? v.a : 8'h00;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < LANES; k++)
        i_datab[(ch*LANES+k)*IPREC +: IPREC] = v.b[ch];
      i_datac[ch*OPREC +: OPREC] = v.dc[ch];
    end
    i_accum_addr = v.addr;
    i_accum      = acc;
    i_last       = last;
    i_reduce     = v.reduce;
    i_mode       = v.mode;
    i_shift      = v.shift;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic applyStimulus(input vec_t v, input logic acc, input logic last);
    int waited;
    waited = 0;
    @(negedge clk);
    setInputs(v, acc, last);
    i_valid = 1'b1;
    while (!o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkVal("accept o_ready", 32'(o_ready), 32'd1);
    if (o_ready)
      @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Waits for the FIFO head, compares every channel, then pops it.
  task automatic checkOutput(input string name, input logic [3:0][31:0] exp);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!o_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!o_valid) begin
      checkVal({name, " o_valid"}, 32'(o_valid), 32'd1);
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++)
        checkVal($sformatf("%s ch%0d", name, ch), o_result[ch*OPREC +: OPREC], exp[ch]);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int acc;
    int waited;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    i_valid      = 1'b0;
    i_ready      = 1'b0;
    i_dataa      = '0;
    i_datab      = '0;
    i_datac      = '0;
    i_accum_addr = '0;
    i_accum      = 1'b0;
    i_last       = 1'b0;
    i_reduce     = 1'b0;
    i_mode       = 2'd0;
    i_shift      = '0;

    vq.push_back(makeVec(64, -3, 5, -7, 127, -128, 0, 0, 0, 0, 40, 0, 0, 0,
                         -960, 1344, -24384, 24576));
    vq.push_back(makeVec(10, -128, -128, 127, 1, 0, 0, 0, 0, 0, 41, 0, 3, 0,
                         163840, -162560, -1280, 0));
    vq.push_back(makeVec(1, 0, 0, 0, 0, 0, 1000, 1020, -1000, 5, 42, 1, 1, 3,
                         125, 127, -125, 1));
    vq.push_back(makeVec(1, 0, 0, 0, 0, 0, -300, 127, -128, 300, 43, 1, 1, 0,
                         -128, 127, -128, 127));
    vq.push_back(makeVec(1, 0, 0, 0, 0, 0, -40, 40, 1000, -1, 44, 1, 2, 2,
                         0, 10, 127, 0));
    vq.push_back(makeVec(1, 1, 7, 1, -1, 3, -5, 32'h7FFFFFFF, 32'h80000000, 10, 45, 1, 0, 0,
                         2, 32'h80000000, 32'h7FFFFFFF, 13));
    vq.push_back(makeVec(64, -128, -128, 127, 2, -2, 0, 0, 0, 0, 46, 0, 1, 13,
                         127, -127, -2, 2));

    #12;
    checkVal("reset o_valid", 32'(o_valid), 32'd0);
    checkVal("reset o_ready", 32'(o_ready), 32'd0);
    checkVal("reset o_result", o_result[31:0] | o_result[63:32] | o_result[95:64] | o_result[127:96],
             32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkVal("post-reset o_ready", 32'(o_ready), 32'd1);

    // Empty-FIFO latency with all lanes active.
    applyStimulus(makeVec(64, 1, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 128, 128, 128, 128), 1'b0, 1'b1);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = i;
        break;
      end
    end
    checkVal("latency", 32'(lat), 32'd11);
    checkOutput("allones", mk4(128, 128, 128, 128));

    foreach (vq[i]) begin
      applyStimulus(vq[i], 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d", i), vq[i].exp);
    end

    // Four back-to-back beats to address 3 exercise write-stage forwarding.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      setInputs(makeVec(10, 1, k+1, 2*(k+1), 3*(k+1), 4*(k+1), 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0),
                k != 0, k == 3);
      i_valid = 1'b1;
      checkVal($sformatf("b2b ready%0d", k), 32'(o_ready), 32'd1);
    end
    @(negedge clk);
    i_valid = 1'b0;
    checkOutput("accum", mk4(100, 200, 300, 400));
    repeat (20) @(negedge clk);
    checkVal("accum single output", 32'(o_valid), 32'd0);

    // Backpressure: downstream stalled, offer 12 last beats.
    acc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (o_ready && acc < 12) begin
        setInputs(makeVec(1, acc+1, 1, 2, 3, 4, 0, 0, 0, 0, 16+acc, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
        i_valid = 1'b1;
        acc++;
      end else begin
        i_valid = 1'b0;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    checkVal("bp accepts", 32'(acc), 32'd8);
    repeat (20) @(negedge clk);
    checkVal("bp full o_ready", 32'(o_ready), 32'd0);
    checkVal("bp full o_valid", 32'(o_valid), 32'd1);
    checkVal("bp head stable", o_result[63:32], 32'd2);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("bp%0d", k), mk4(k+1, 2*(k+1), 3*(k+1), 4*(k+1)));
    @(negedge clk);
    checkVal("bp drained o_ready", 32'(o_ready), 32'd1);

    // Reset with one result buffered and two in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setInputs(makeVec(1, k+1, 1, 1, 1, 1, 0, 0, 0, 0, 50+k, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
      i_valid = 1'b1;
    end
    @(negedge clk);
    i_valid = 1'b0;
    waited = 0;
    while (!o_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkVal("rst pre o_valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkVal("rst o_valid", 32'(o_valid), 32'd0);
    checkVal("rst o_ready", 32'(o_ready), 32'd0);
    checkVal("rst o_result", o_result[31:0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rst release o_ready", 32'(o_ready), 32'd1);
    repeat (20) @(negedge clk);
    checkVal("rst no stale", 32'(o_valid), 32'd0);

    // Accumulation memory survives reset.
    applyStimulus(makeVec(10, 1, 1, 2, 3, 4, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    checkOutput("mem kept", mk4(110, 220, 330, 440));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
